// File: rtl/load_store_seq_pkg.sv
// Shared definitions for the load/store sequencer: op and state encodings
// plus small helpers for classifying ops and building store byte lanes.
package load_store_seq_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    function automatic logic is_load(input op_t op);
        case (op)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input op_t op);
        case (op)
            OP_SW, OP_SH, OP_SB: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Byte ops can sit on any lane, so only word and half ops are checked.
    function automatic logic is_misaligned(input op_t op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input op_t op, input logic [1:0] addr_lo);
        case (op)
            OP_SW:   return 4'b1111;
            OP_SH:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << addr_lo;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input op_t op, input logic [31:0] wdata);
        case (op)
            OP_SH:   return {2{wdata[15:0]}};
            OP_SB:   return {4{wdata[7:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_seq_extend.sv
// Load data alignment: selects the addressed half/byte lane of a read word
// and sign- or zero-extends it to 32 bits.
module load_extend
    import load_store_seq_pkg::*;
(
    input  logic [31:0] rdata,
    input  op_t         op,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        data = rdata;
        case (op)
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0000, half_sel};
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h000000, byte_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_seq.sv
// Multi-cycle load/store sequencer: accepts one request at a time, runs the
// memory handshake with an optional timeout, and returns a single response.
module load_store_seq
    import load_store_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic        resp_load,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    state_t        state_next;
    op_t           op_in;
    op_t           op_q;
    logic [1:0]    addr_lo_q;
    logic [4:0]    rd_q;
    logic [31:0]   data_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic          we_q;
    logic [CW-1:0] count;
    logic          accept;
    logic          misaligned;
    logic          timeout_hit;
    logic [31:0]   ext_data;

    assign op_in       = op_t'(req_op);
    assign accept      = req_valid && (state == S_IDLE);
    assign misaligned  = is_misaligned(op_in, req_addr[1:0]);
    // An ack arriving on the final allowed cycle still wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && (count == LAST_COUNT);

    load_extend u_extend (
        .rdata   (mem_rdata),
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = misaligned ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_next = S_RESP;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_RESP:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_req    = (state == S_REQ);
        mem_we     = (state == S_REQ) && we_q;
        mem_wstrb  = (state == S_REQ) ? strb_q : 4'b0000;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        resp_valid = (state == S_RESP) || (state == S_ERR);
        resp_err   = (state == S_ERR);
        resp_load  = resp_valid && is_load(op_q);
        resp_rd    = resp_valid ? rd_q : 5'd0;
        resp_data  = (state == S_RESP) ? data_q : 32'h0;
    end

    // Request fields and memory-side registers are captured on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LW;
            addr_lo_q <= 2'b00;
            rd_q      <= 5'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            strb_q    <= 4'b0000;
            we_q      <= 1'b0;
        end else if (accept) begin
            op_q      <= op_in;
            addr_lo_q <= req_addr[1:0];
            rd_q      <= req_rd;
            if (!misaligned) begin
                addr_q  <= {req_addr[31:2], 2'b00};
                wdata_q <= store_data(op_in, req_wdata);
                strb_q  <= store_strb(op_in, req_addr[1:0]);
                we_q    <= is_store(op_in);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 32'h0;
        end else if ((state == S_REQ) && mem_ack) begin
            data_q <= is_load(op_q) ? ext_data : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (state != S_REQ) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_load_store_seq.sv
// Scoreboard bench for load_store_seq: directed requests push expected memory
// and response records; responder and monitor processes pop and compare them.
module tb_load_store_seq;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        int          delay;
    } exp_mem_t;

    typedef struct {
        logic [38:0] resp;
        int          cyc;
    } exp_resp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_load;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_err;

    exp_mem_t  mem_q[$];
    exp_resp_t resp_q[$];
    int        tests_run;
    int        tests_failed;
    int        cyc;
    int        req_run;

    load_store_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_load  (resp_load),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Memory responder: checks the request on its first cycle, then acks after the scripted delay.
    initial begin : responder
        exp_mem_t cur;
        int       req_cycles;
        req_cycles = 0;
        req_run    = 0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        cur        = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, strb: 4'h0, rdata: 32'h0, delay: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack    = 1'b0;
                req_cycles = 0;
            end else if (mem_req) begin
                if (req_cycles == 0) begin
                    if (mem_q.size() == 0) begin
                        check_output("unexpected_mem_req", 64'd1, 64'd0);
                    end else begin
                        cur = mem_q.pop_front();
                        check_output("mem_addr", 64'(mem_addr), 64'(cur.addr));
                        check_output("mem_we", 64'(mem_we), 64'(cur.we));
                        if (cur.we) begin
                            check_output("mem_wstrb", 64'(mem_wstrb), 64'(cur.strb));
                            check_output("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                        end
                    end
                end
                req_cycles++;
                mem_ack   = (cur.delay != 0) && (req_cycles == cur.delay);
                mem_rdata = mem_ack ? cur.rdata : ~cur.rdata;
            end else begin
                if (req_cycles != 0) req_run = req_cycles;
                req_cycles = 0;
                mem_ack    = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (resp_q.size() == 0) begin
                    check_output("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = resp_q.pop_front();
                    check_output("resp_fields", 64'({resp_load, resp_rd, resp_err, resp_data}), 64'(e.resp));
                    check_output("resp_cycle", 64'(cyc), 64'(e.cyc));
                    check_output("mem_req_in_resp", 64'(mem_req), 64'd0);
                end
            end
        end
    end

    // Issues one request from a negedge; returns at the negedge after acceptance.
    task automatic apply_stimulus(
        input logic [2:0]  op,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input logic [31:0] rdata,
        input int          delay,
        input logic [31:0] exp_data,
        input logic        exp_err,
        input int          lat,
        input bit          exp_mem,
        input bit          exp_resp,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wdata
    );
        int        waited;
        int        acc;
        logic      ld;
        exp_resp_t r;
        ld = (op <= 3'd4);
        if (exp_mem) begin
            mem_q.push_back('{we: !ld, addr: {addr[31:2], 2'b00}, wdata: exp_wdata,
                              strb: exp_strb, rdata: rdata, delay: delay});
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check_output("req_ready_wait", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (exp_resp) begin
            r.resp = {ld, rd, exp_err, exp_data};
            r.cyc  = acc + lat;
            resp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
        check_output("ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (resp_q.size() != 0 || mem_q.size() != 0) begin
            check_output("drain_timeout", 64'(resp_q.size() + mem_q.size()), 64'd0);
            resp_q.delete();
            mem_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        repeat (3) @(negedge clk);
        check_output("rst_mem_req", 64'(mem_req), 64'd0);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd1);
        check_output("rst_outputs", 64'({mem_we, mem_wstrb, resp_err, resp_data}), 64'd0);

        // Loads with lane select and extension
        apply_stimulus(3'd3, 32'h103, 32'h0, 5'd7,  32'h80FF_1234, 1, 32'hFFFF_FF80, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        wait_drain();
        apply_stimulus(3'd2, 32'h202, 32'h0, 5'd9,  32'h8001_7FFF, 1, 32'h0000_8001, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd1, 32'h202, 32'h0, 5'd10, 32'h8001_7FFF, 2, 32'hFFFF_8001, 1'b0, 2, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd0, 32'h200, 32'h0, 5'd11, 32'h8001_7FFF, 1, 32'h8001_7FFF, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd1, 32'h200, 32'h0, 5'd12, 32'h8001_7FFF, 1, 32'h0000_7FFF, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd4, 32'h101, 32'h0, 5'd13, 32'h80FF_1234, 1, 32'h0000_0012, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd3, 32'h102, 32'h0, 5'd0,  32'h80FF_1234, 1, 32'hFFFF_FFFF, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        wait_drain();

        // Stores: lane-replicated data and byte strobes
        apply_stimulus(3'd7, 32'h003, 32'h0000_00AB, 5'd0, 32'h0, 1, 32'h0, 1'b0, 1, 1, 1, 4'b1000, 32'hABAB_ABAB);
        apply_stimulus(3'd6, 32'h202, 32'h1234_5678, 5'd0, 32'h0, 1, 32'h0, 1'b0, 1, 1, 1, 4'b1100, 32'h5678_5678);
        apply_stimulus(3'd5, 32'h040, 32'hDEAD_BEEF, 5'd0, 32'h0, 3, 32'h0, 1'b0, 3, 1, 1, 4'b1111, 32'hDEAD_BEEF);
        apply_stimulus(3'd7, 32'h000, 32'h0000_1234, 5'd0, 32'h0, 1, 32'h0, 1'b0, 1, 1, 1, 4'b0001, 32'h3434_3434);
        wait_drain();

        // Misaligned: no memory access, error response the cycle after accept
        apply_stimulus(3'd0, 32'h006, 32'h0, 5'd3, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1, 4'h0, 32'h0);
        apply_stimulus(3'd6, 32'h001, 32'h0, 5'd0, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1, 4'h0, 32'h0);
        apply_stimulus(3'd2, 32'h003, 32'h0, 5'd4, 32'h0, 1, 32'h0, 1'b1, 0, 0, 1, 4'h0, 32'h0);
        wait_drain();

        // Timeout with no ack, then ack on the last allowed cycle
        apply_stimulus(3'd0, 32'h500, 32'h0, 5'd5, 32'h0, 0, 32'h0, 1'b1, TIMEOUT, 1, 1, 4'h0, 32'h0);
        wait_drain();
        check_output("timeout_req_cycles", 64'(req_run), 64'(TIMEOUT));
        apply_stimulus(3'd0, 32'h504, 32'h0, 5'd6, 32'hCAFE_F00D, TIMEOUT, 32'hCAFE_F00D, 1'b0, TIMEOUT, 1, 1, 4'h0, 32'h0);
        wait_drain();
        check_output("late_ack_req_cycles", 64'(req_run), 64'(TIMEOUT));

        // Back-to-back requests, 2-cycle ack delay, served in order
        apply_stimulus(3'd0, 32'h010, 32'h0,         5'd1, 32'h1111_2222, 2, 32'h1111_2222, 1'b0, 2, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd4, 32'h021, 32'h0,         5'd2, 32'h0000_AB00, 2, 32'h0000_00AB, 1'b0, 2, 1, 1, 4'h0, 32'h0);
        apply_stimulus(3'd6, 32'h012, 32'h0000_BEEF, 5'd0, 32'h0,         2, 32'h0,         1'b0, 2, 1, 1, 4'b1100, 32'hBEEF_BEEF);
        wait_drain();

        // Reset in the middle of an access drops mem_req and loses the request
        apply_stimulus(3'd0, 32'h080, 32'h0, 5'd8, 32'h0, 0, 32'h0, 1'b0, 0, 1, 0, 4'h0, 32'h0);
        @(negedge clk);
        check_output("mid_req_mem_req", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_drops_mem_req", 64'(mem_req), 64'd0);
        check_output("reset_no_resp", 64'(resp_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_output("post_reset_ready", 64'(req_ready), 64'd1);
        apply_stimulus(3'd3, 32'h103, 32'h0, 5'd14, 32'h80FF_1234, 1, 32'hFFFF_FF80, 1'b0, 1, 1, 1, 4'h0, 32'h0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
